// File: rtl/safety_pkg.sv
// Shared definitions for the laser safety interlock: state encoding and fault bit map.
package safety_pkg;

  localparam int NUM_FAULTS_DEF = 5;

  localparam int FLT_PULSE_LO = 0;
  localparam int FLT_PULSE_HI = 1;
  localparam int FLT_RATE     = 2;
  localparam int FLT_PEAK     = 3;
  localparam int FLT_CW       = 4;

  typedef enum logic [1:0] {
    ST_INIT      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_TRIPPED   = 2'd2,
    ST_HOLD_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/safety_interlock_if.sv
// Fault/control/status bundle between the register file side (master) and the interlock (slave).
interface safety_interlock_if #(
  parameter int NUM_FAULTS = 5,
  parameter int TS_WIDTH   = 32,
  parameter int CNT_WIDTH  = 8
);
  logic [NUM_FAULTS-1:0] fault_in;
  logic [NUM_FAULTS-1:0] fault_mask;
  logic                  laser_ready;
  logic                  clear_req;
  logic                  shutdown;
  logic                  arm_ok;
  logic                  clear_ack;
  logic [1:0]            state;
  logic [NUM_FAULTS-1:0] first_fault;
  logic [NUM_FAULTS-1:0] fault_sticky;
  logic [CNT_WIDTH-1:0]  trip_count;
  logic [TS_WIDTH-1:0]   trip_time;

  modport master (
    output fault_in, fault_mask, laser_ready, clear_req,
    input  shutdown, arm_ok, clear_ack, state, first_fault, fault_sticky, trip_count, trip_time
  );

  modport slave (
    input  fault_in, fault_mask, laser_ready, clear_req,
    output shutdown, arm_ok, clear_ack, state, first_fault, fault_sticky, trip_count, trip_time
  );
endinterface

// File: rtl/holdoff_timer.sv
// Minimum shutdown hold-off: counter cleared by load, advanced by en, done at HOLDOFF_CYCLES-1.
module holdoff_timer #(
  parameter int HOLDOFF_CYCLES = 25000
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [W-1:0] TC = W'(HOLDOFF_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)             cnt <= '0;
    else if (load)         cnt <= '0;
    else if (en && !done)  cnt <= cnt + 1'b1;
  end

  assign done = (cnt == TC);

endmodule

// File: rtl/safety_interlock.sv
// Fail-safe laser/TA shutdown: masks and combines fault flags, latches and timestamps the first
// trip, holds shutdown for a minimum time and re-arms only on an accepted host clear.
//
//   state      | meaning
//   INIT       | waiting for laser_ready with no unmasked fault; shutdown asserted
//   ARMED      | running; shutdown follows unmasked faults combinationally
//   TRIPPED    | fault captured; hold-off timer running, clears ignored
//   HOLD_DONE  | hold-off elapsed; clear edge with faults gone re-arms
module safety_interlock
  import safety_pkg::*;
#(
  parameter int NUM_FAULTS     = NUM_FAULTS_DEF,
  parameter int HOLDOFF_CYCLES = 25000,
  parameter int TS_WIDTH       = 32,
  parameter int CNT_WIDTH      = 8
) (
  input logic               clk,
  input logic               rstn,
  safety_interlock_if.slave bus
);

  state_t                state_q, state_nxt;
  logic                  clear_req_q;
  logic                  clear_ack_q;
  logic [TS_WIDTH-1:0]   ts;
  logic [NUM_FAULTS-1:0] first_fault_q;
  logic [NUM_FAULTS-1:0] sticky_q;
  logic [CNT_WIDTH-1:0]  trip_count_q;
  logic [TS_WIDTH-1:0]   trip_time_q;

  logic [NUM_FAULTS-1:0] act_vec;
  logic                  active;
  logic                  clr_edge;
  logic                  trip;
  logic                  accept;
  logic                  tmr_en;
  logic                  tmr_done;
  logic                  shutdown_c;

  assign act_vec  = bus.fault_in & ~bus.fault_mask;
  assign active   = |act_vec;
  assign clr_edge = bus.clear_req & ~clear_req_q;

  holdoff_timer #(.HOLDOFF_CYCLES(HOLDOFF_CYCLES)) u_holdoff (
    .clk  (clk),
    .rstn (rstn),
    .load (trip),
    .en   (tmr_en),
    .done (tmr_done)
  );

  always_comb begin
    state_nxt  = state_q;
    shutdown_c = 1'b1;
    trip       = 1'b0;
    accept     = 1'b0;
    tmr_en     = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (bus.laser_ready && !active) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        shutdown_c = active;
        if (active) begin
          state_nxt = ST_TRIPPED;
          trip      = 1'b1;
        end
      end
      ST_TRIPPED: begin
        tmr_en = 1'b1;
        if (tmr_done) state_nxt = ST_HOLD_DONE;
      end
      ST_HOLD_DONE: begin
        if (clr_edge && !active) begin
          state_nxt = ST_ARMED;
          accept    = 1'b1;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
    // Loss of laser_ready overrides everything, including a coincident trip or clear.
    if (!bus.laser_ready) begin
      state_nxt = ST_INIT;
      trip      = 1'b0;
      accept    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_INIT;
      clear_req_q   <= 1'b0;
      clear_ack_q   <= 1'b0;
      ts            <= '0;
      first_fault_q <= '0;
      sticky_q      <= '0;
      trip_count_q  <= '0;
      trip_time_q   <= '0;
    end else begin
      state_q     <= state_nxt;
      clear_req_q <= bus.clear_req;
      clear_ack_q <= accept;
      ts          <= ts + 1'b1;
      if (trip) begin
        first_fault_q <= act_vec;
        trip_time_q   <= ts;
        if (trip_count_q != '1) trip_count_q <= trip_count_q + 1'b1;
      end
      if (accept)
        sticky_q <= '0;
      else if (trip || state_q == ST_TRIPPED || state_q == ST_HOLD_DONE)
        sticky_q <= sticky_q | act_vec;
    end
  end

  assign bus.shutdown     = shutdown_c;
  assign bus.arm_ok       = (state_q == ST_ARMED) && !active;
  assign bus.clear_ack    = clear_ack_q;
  assign bus.state        = state_q;
  assign bus.first_fault  = first_fault_q;
  assign bus.fault_sticky = sticky_q;
  assign bus.trip_count   = trip_count_q;
  assign bus.trip_time    = trip_time_q;

endmodule

// File: tb/tb_safety_interlock.sv
// Directed bench for safety_interlock with a short hold-off; expected values are hand-derived.
module tb_safety_interlock;
  import safety_pkg::*;

  localparam int HOLD = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] tb_ts;
  int          n_chk = 0;
  int          n_fail = 0;
  int          exp_cnt;

  always #5 clk = ~clk;

  // Reference timestamp: cycles since reset release.
  always @(posedge clk or negedge rstn)
    if (!rstn) tb_ts <= 0;
    else       tb_ts <= tb_ts + 1;

  safety_interlock_if #(.NUM_FAULTS(5), .TS_WIDTH(32), .CNT_WIDTH(8)) bus ();

  safety_interlock #(
    .NUM_FAULTS(5), .HOLDOFF_CYCLES(HOLD), .TS_WIDTH(32), .CNT_WIDTH(8)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_pulse();
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
  endtask

  initial begin
    bus.fault_in    = '0;
    bus.fault_mask  = '0;
    bus.laser_ready = 1'b0;
    bus.clear_req   = 1'b0;

    // Reset values
    tick(3);
    check("rst_shutdown", bus.shutdown, 1);
    check("rst_arm_ok", bus.arm_ok, 0);
    check("rst_ack", bus.clear_ack, 0);
    check("rst_state", bus.state, ST_INIT);
    check("rst_first", bus.first_fault, 0);
    check("rst_sticky", bus.fault_sticky, 0);
    check("rst_count", bus.trip_count, 0);
    check("rst_time", bus.trip_time, 0);
    rstn = 1'b1;

    // Arm at cycle 10
    while (tb_ts != 10) tick();
    check("init_shutdown", bus.shutdown, 1);
    bus.laser_ready = 1'b1;
    tick();
    check("arm_state", bus.state, ST_ARMED);
    check("arm_shutdown", bus.shutdown, 0);
    check("arm_ok", bus.arm_ok, 1);

    // Rate fault at timestamp 100
    while (tb_ts != 100) tick();
    bus.fault_in = 5'b00100;
    #1;
    check("trip_comb_shutdown", bus.shutdown, 1);
    check("trip_arm_ok_low", bus.arm_ok, 0);
    tick();
    bus.fault_in = '0;
    check("trip_state", bus.state, ST_TRIPPED);
    check("trip_first", bus.first_fault, 5'b00100);
    check("trip_time", bus.trip_time, 100);
    check("trip_count1", bus.trip_count, 1);
    check("trip_sticky", bus.fault_sticky, 5'b00100);

    // Clear during hold-off is ignored
    tick(9);
    clear_pulse();
    check("early_clr_ack", bus.clear_ack, 0);
    check("early_clr_state", bus.state, ST_TRIPPED);
    tick(5);
    check("holdoff_last", bus.state, ST_TRIPPED);
    check("holdoff_shutdown", bus.shutdown, 1);
    tick();
    check("hold_done", bus.state, ST_HOLD_DONE);

    // Accepted clear
    clear_pulse();
    check("clr_ack", bus.clear_ack, 1);
    check("clr_state", bus.state, ST_ARMED);
    check("clr_sticky", bus.fault_sticky, 0);
    check("clr_first_kept", bus.first_fault, 5'b00100);
    check("clr_time_kept", bus.trip_time, 100);
    tick();
    check("clr_ack_one_cycle", bus.clear_ack, 0);

    // Masked fault does not trip; unmasked one does
    bus.fault_mask = 5'b01000;
    tick();
    bus.fault_in = 5'b01000;
    #1;
    check("mask_shutdown", bus.shutdown, 0);
    tick();
    check("mask_state", bus.state, ST_ARMED);
    bus.fault_in = 5'b11000;
    #1;
    check("mask_trip_shutdown", bus.shutdown, 1);
    tick();
    bus.fault_in = '0;
    check("mask_trip_state", bus.state, ST_TRIPPED);
    check("mask_first", bus.first_fault, 5'b10000);
    check("mask_count", bus.trip_count, 2);
    tick(HOLD);
    check("mask_hold_done", bus.state, ST_HOLD_DONE);

    // Clear with active fault rejected, then accepted
    bus.fault_in = 5'b00001;
    clear_pulse();
    check("rej_ack", bus.clear_ack, 0);
    check("rej_state", bus.state, ST_HOLD_DONE);
    check("rej_sticky", bus.fault_sticky, 5'b10001);
    bus.fault_in = '0;
    tick();
    clear_pulse();
    check("acc_ack", bus.clear_ack, 1);
    check("acc_state", bus.state, ST_ARMED);
    bus.fault_mask = '0;

    // laser_ready drop coincident with a fault: no trip recorded
    bus.laser_ready = 1'b0;
    bus.fault_in = 5'b00010;
    tick();
    check("drop_fault_state", bus.state, ST_INIT);
    check("drop_fault_count", bus.trip_count, 2);
    bus.fault_in = '0;
    bus.laser_ready = 1'b1;
    tick();
    check("rearm_state", bus.state, ST_ARMED);

    // laser_ready drop mid-trip
    bus.fault_in = 5'b00010;
    tick();
    bus.fault_in = '0;
    check("trip3_state", bus.state, ST_TRIPPED);
    bus.laser_ready = 1'b0;
    tick();
    check("drop_trip_state", bus.state, ST_INIT);
    check("drop_trip_shutdown", bus.shutdown, 1);
    check("drop_trip_count", bus.trip_count, 3);
    check("drop_trip_first", bus.first_fault, 5'b00010);
    bus.laser_ready = 1'b1;
    tick();
    check("drop_rearm_state", bus.state, ST_ARMED);
    check("drop_rearm_shutdown", bus.shutdown, 0);

    // Trip counter saturation
    for (int i = 4; i <= 300; i++) begin
      bus.fault_in = 5'b00001;
      tick();
      bus.fault_in = '0;
      exp_cnt = (i > 255) ? 255 : i;
      if (i == 254 || i == 255 || i == 256 || i == 300)
        check($sformatf("sat_count_%0d", i), bus.trip_count, exp_cnt);
      tick(HOLD);
      clear_pulse();
    end
    check("sat_state", bus.state, ST_ARMED);

    // Reset mid-trip
    bus.fault_in = 5'b00100;
    tick();
    bus.fault_in = '0;
    check("pre_rst_state", bus.state, ST_TRIPPED);
    rstn = 1'b0;
    #1;
    check("midrst_shutdown", bus.shutdown, 1);
    check("midrst_state", bus.state, ST_INIT);
    check("midrst_count", bus.trip_count, 0);
    check("midrst_time", bus.trip_time, 0);
    check("midrst_first", bus.first_fault, 0);
    tick(2);
    check("midrst_hold_shutdown", bus.shutdown, 1);
    rstn = 1'b1;
    tick();
    check("post_rst_state", bus.state, ST_ARMED);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
